fifo_reader: RTL and testbench

- Read-side controller for the main FIFO. It drains entries under watermark control and presents them on a valid/ready stream to the downstream consumer.
- It never reads an empty FIFO and absorbs the FIFO's one-cycle read latency in a 2-entry output buffer. It also counts FIFO error events.
- It sits between the FIFO outputs (fifo_empty, almost_empty, fifo_data_out, fifo_error) and the next pipeline stage.

---
 rtl/fifo_reader_pkg.sv | 24 ++
 rtl/fifo_reader_skid.sv | 58 +++++
 rtl/fifo_reader.sv | 92 +++++++++
 tb/tb_fifo_reader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO read-side controller: state encoding,
// default widths and the read-space rule.
package fifo_reader_pkg;

  localparam int unsigned DATA_SIZE_DEF       = 12;
  localparam int unsigned MAIN_QUEUE_SIZE_DEF = 3;
  localparam int unsigned ERR_CNT_W_DEF       = 8;
  localparam int unsigned OCC_W               = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // A new read is safe when, after this cycle's pop, at most one word is
  // still held or returning, so its data always finds a free buffer slot.
  function automatic logic read_space_ok(input logic [OCC_W-1:0] occ,
                                         input logic inflight,
                                         input logic pop);
    return (3'(occ) + 3'(inflight)) <= (3'd1 + 3'(pop));
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer absorbing the FIFO read latency; head drives the
// downstream data and holds its last value when empty.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] head,
  output logic                 valid,
  output logic [OCC_W-1:0]     occupancy
);

  logic [DATA_SIZE-1:0] tail;
  logic                 pop_ok;

  assign valid  = (occupancy != OCC_W'(0));
  assign pop_ok = pop && valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occupancy == OCC_W'(0)) begin
            head      <= push_data;
            occupancy <= OCC_W'(1);
          end else if (occupancy == OCC_W'(1)) begin
            tail      <= push_data;
            occupancy <= OCC_W'(2);
          end
        end
        2'b01: begin
          if (occupancy == OCC_W'(2)) head <= tail;
          occupancy <= occupancy - OCC_W'(1);
        end
        // Simultaneous push and pop: occupancy unchanged, order kept.
        2'b11: begin
          if (occupancy == OCC_W'(2)) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the main FIFO: watermark/flush draining FSM,
// safe read issue, output buffering and a saturating error counter.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_SIZE       = DATA_SIZE_DEF,
  parameter int unsigned MAIN_QUEUE_SIZE = MAIN_QUEUE_SIZE_DEF,
  parameter int unsigned ERR_CNT_W       = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic                 almost_empty,
  input  logic                 fifo_error,
  input  logic [DATA_SIZE-1:0] fifo_data_out,
  output logic                 read,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  if (MAIN_QUEUE_SIZE < 1) begin : g_bad_queue_size
    $error("fifo_reader: MAIN_QUEUE_SIZE must be at least 1");
  end

  state_t           state;
  logic             inflight;
  logic [OCC_W-1:0] occupancy;
  logic             pop_now;
  logic             draining;

  assign pop_now  = valid && ready;
  assign draining = ((state == ST_DRAIN) && enable) || (state == ST_FLUSH);
  assign read     = !reset && !fifo_empty && draining
                    && read_space_ok(occupancy, inflight, pop_now);
  assign busy     = (state != ST_IDLE) || (occupancy != OCC_W'(0)) || inflight;

  // Drain FSM; almost_empty only gates entry, draining runs to empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      inflight <= 1'b0;
    end else begin
      inflight <= read;
      case (state)
        ST_IDLE: begin
          if (flush && !fifo_empty)
            state <= ST_FLUSH;
          else if (enable && !almost_empty && !fifo_empty)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (flush)
            state <= ST_FLUSH;
          else if (fifo_empty || !enable)
            state <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (fifo_empty) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_count <= '0;
    else if (fifo_error && (err_count != ERR_MAX))
      err_count <= err_count + ERR_CNT_W'(1);
  end

  fifo_reader_skid #(
    .DATA_SIZE (DATA_SIZE)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (ready),
    .head      (data_out),
    .valid     (valid),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural FIFO with one-cycle read latency and an
// end-to-end word-order scoreboard.
module tb_fifo_reader;

  localparam int unsigned DW     = 12;
  localparam int unsigned EW     = 8;
  localparam int unsigned AE_THR = 1;
  localparam int          ERR_SAT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset, enable, flush, fifo_empty, almost_empty, fifo_error, ready;
  logic [DW-1:0] fifo_data_out, data_out;
  logic          read, valid, busy;
  logic [EW-1:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] fq[$];     // FIFO contents
  logic [DW-1:0] exp_q[$];  // words taken from FIFO, not yet delivered
  logic [DW-1:0] dlv[$];    // words delivered downstream
  int cyc, n_reads, first_read_cyc, last_read_cyc, first_pop_cyc, err_model;
  logic          hold_prev;
  logic [DW-1:0] hold_data;

  fifo_reader #(
    .DATA_SIZE       (DW),
    .MAIN_QUEUE_SIZE (3),
    .ERR_CNT_W       (EW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .flush         (flush),
    .fifo_empty    (fifo_empty),
    .almost_empty  (almost_empty),
    .fifo_error    (fifo_error),
    .fifo_data_out (fifo_data_out),
    .read          (read),
    .data_out      (data_out),
    .valid         (valid),
    .ready         (ready),
    .busy          (busy),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  function automatic void set_flags();
    fifo_empty   = (fq.size() == 0);
    almost_empty = (fq.size() <= AE_THR);
  endfunction

  function automatic void clear_stats();
    n_reads = 0; first_read_cyc = -1; last_read_cyc = -1; first_pop_cyc = -1;
    cyc = 0; dlv.delete();
  endfunction

  // One clock cycle: observe at mid-cycle, then model the FIFO after the edge.
  task automatic tick();
    logic rd, pp;
    #2;
    rd = read;
    pp = valid && ready;
    if (reset) begin
      if (rd) begin
        vectors++;
        miscompares++;
        $display("FAIL read_in_reset: read=%b required 0", rd);
      end
    end else begin
      if (hold_prev) begin
        vectors++;
        if (valid !== 1'b1 || data_out !== hold_data) begin
          miscompares++;
          $display("FAIL hold: valid=%b data_out=%h required valid=1 data_out=%h",
                   valid, data_out, hold_data);
        end
      end
      if (rd) begin
        vectors++;
        if (fifo_empty || (exp_q.size() - (pp ? 1 : 0)) > 1) begin
          miscompares++;
          $display("FAIL read_guard: cyc=%0d fifo_empty=%b pending=%0d required no read",
                   cyc, fifo_empty, exp_q.size());
        end
        n_reads++;
        if (first_read_cyc < 0) first_read_cyc = cyc;
        last_read_cyc = cyc;
      end
      if (pp) begin
        vectors++;
        if (exp_q.size() == 0 || data_out !== exp_q[0]) begin
          miscompares++;
          $display("FAIL deliver: cyc=%0d data_out=%h required %h", cyc, data_out,
                   (exp_q.size() != 0) ? exp_q[0] : 'x);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        dlv.push_back(data_out);
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
    hold_prev = !reset && valid && !ready;
    hold_data = data_out;
    if (reset) err_model = 0;
    else if (fifo_error) err_model = (err_model < ERR_SAT) ? err_model + 1 : ERR_SAT;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) exp_q.delete();
    if (rd && !reset && fq.size() != 0) begin
      fifo_data_out = fq.pop_front();
      exp_q.push_back(fifo_data_out);
    end else begin
      fifo_data_out = DW'($urandom);
    end
    set_flags();
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int budget, input bit rand_ready, input string name);
    int n = 0;
    tick();
    tick();
    while ((busy || fq.size() != 0 || exp_q.size() != 0) && n < budget) begin
      if (rand_ready) ready = 1'($urandom);
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: cycles=%0d required < %0d", name, n, budget);
    end
    ready = 1'b1;
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b valid=%b required 0 0", name, busy, valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (read !== 1'b0 || valid !== 1'b0 || data_out !== '0 || busy !== 1'b0 || err_count !== '0) begin
      miscompares++;
      $display("FAIL reset: read=%b valid=%b data_out=%h busy=%b err=%0d required all 0",
               read, valid, data_out, busy, err_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_watermark();
    enable = 1'b0;
    ready  = 1'b1;
    for (int i = 0; i < 6; i++) fq.push_back(DW'(12'h01A + 16 * i));
    set_flags();
    clear_stats();
    enable = 1'b1;
    run_until_idle(60, 1'b0, "watermark");
    vectors++;
    if (n_reads != 6 || last_read_cyc - first_read_cyc != 5) begin
      miscompares++;
      $display("FAIL wm_reads: reads=%0d span=%0d required 6 5", n_reads,
               last_read_cyc - first_read_cyc);
    end
    vectors++;
    if (first_pop_cyc - first_read_cyc != 2) begin
      miscompares++;
      $display("FAIL wm_latency: read->valid=%0d required 2", first_pop_cyc - first_read_cyc);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= dlv.size() || dlv[i] !== DW'(12'h01A + 16 * i)) begin
        miscompares++;
        $display("FAIL wm_word%0d: got %h required %h", i,
                 (i < dlv.size()) ? dlv[i] : 'x, DW'(12'h01A + 16 * i));
      end
    end
    check_idle("wm");
  endtask

  task automatic test_below_watermark();
    enable = 1'b1;
    fq.push_back(12'h0AA);
    set_flags();
    clear_stats();
    repeat (20) tick();
    vectors++;
    if (n_reads != 0) begin
      miscompares++;
      $display("FAIL bw_noread: reads=%0d required 0", n_reads);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_until_idle(30, 1'b0, "bw");
    vectors++;
    if (n_reads != 1 || dlv.size() != 1 || dlv[0] !== 12'h0AA) begin
      miscompares++;
      $display("FAIL bw_flush: reads=%0d delivered=%0d required 1 1 word 0aa",
               n_reads, dlv.size());
    end
    check_idle("bw");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] src[$];
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      src.push_back(DW'($urandom));
      fq.push_back(src[i]);
    end
    set_flags();
    clear_stats();
    enable = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 6; i++) begin
        ready = pat[i];
        tick();
      end
    run_until_idle(200, 1'b1, "bp");
    vectors++;
    if (dlv.size() != src.size() || dlv != src) begin
      miscompares++;
      $display("FAIL bp_stream: delivered=%0d required %0d in order", dlv.size(), src.size());
    end
    check_idle("bp");
  endtask

  task automatic test_empty_guard();
    logic [DW-1:0] src[$];
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src.push_back(DW'($urandom));
      fq.push_back(src[src.size() - 1]);
    end
    set_flags();
    clear_stats();
    for (int c = 0; c < 60; c++) begin
      ready = 1'($urandom);
      if (c % 3 == 2) begin
        src.push_back(DW'($urandom));
        fq.push_back(src[src.size() - 1]);
        set_flags();
      end
      tick();
    end
    flush = 1'b1;
    run_until_idle(200, 1'b1, "eg");
    flush = 1'b0;
    vectors++;
    if (n_reads != src.size() || dlv != src) begin
      miscompares++;
      $display("FAIL eg_stream: reads=%0d delivered=%0d required %0d", n_reads,
               dlv.size(), src.size());
    end
    check_idle("eg");
  endtask

  task automatic test_err_count();
    err_model  = int'(err_count);
    fifo_error = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (c == 9 || c == 299) begin
        vectors++;
        if (err_count !== EW'(err_model)) begin
          miscompares++;
          $display("FAIL err_c%0d: err_count=%0d required %0d", c, err_count, err_model);
        end
      end
    end
    fifo_error = 1'b0;
    tick();
    vectors++;
    if (err_count !== EW'(ERR_SAT)) begin
      miscompares++;
      $display("FAIL err_sat: err_count=%0d required %0d", err_count, ERR_SAT);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (err_count !== '0) begin
      miscompares++;
      $display("FAIL err_reset: err_count=%0d required 0", err_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] first_next;
    int remaining;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(DW'(12'h100 + i));
    set_flags();
    clear_stats();
    enable = 1'b1;
    ready  = 1'b1;
    repeat (4) tick();
    ready = 1'b0;
    tick();
    vectors++;
    if (exp_q.size() < 2) begin
      miscompares++;
      $display("FAIL rm_setup: pending=%0d required >= 2", exp_q.size());
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (valid !== 1'b0 || read !== 1'b0 || data_out !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_reset: valid=%b read=%b data_out=%h busy=%b required 0 0 000 0",
               valid, read, data_out, busy);
    end
    reset      = 1'b0;
    ready      = 1'b1;
    first_next = fq[0];
    remaining  = fq.size();
    clear_stats();
    flush = 1'b1;
    run_until_idle(100, 1'b0, "rm");
    flush = 1'b0;
    vectors++;
    if (dlv.size() != remaining || dlv[0] !== first_next) begin
      miscompares++;
      $display("FAIL rm_resume: delivered=%0d first=%h required %0d first=%h",
               dlv.size(), (dlv.size() != 0) ? dlv[0] : 'x, remaining, first_next);
    end
    check_idle("rm");
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; flush = 1'b0; fifo_error = 1'b0; ready = 1'b1;
    fifo_data_out = '0; hold_prev = 1'b0; hold_data = '0; err_model = 0;
    set_flags();
    clear_stats();
    @(negedge clk);
    test_reset();
    test_watermark();
    test_below_watermark();
    test_backpressure();
    test_empty_guard();
    test_err_count();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
